scramble_sequencer: RTL and testbench

SCRAMBLE_SEQUENCER -- requirements
Module: scramble_sequencer

---
 rtl/scramble_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_scramble_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scramble_sequencer.sv
// scramble_sequencer
//   Issues a burst of NUM_MOVES pseudo-random line moves (one every
//   GAP_CYCLES+1 clocks) to a 4x4 cell array, then hands control to the
//   player. Player moves are passed through one cycle later when they are
//   legal. A level-high win while playing ends the game in SOLVED.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   start      : single-cycle request for a new scramble (restarts from any state)
//   rand_in    : [2] row(0)/column(1), [1:0] line index for scramble moves
//   user_fire  : single-cycle debounced fire pulse from the player
//   user_rc    : one-hot player line select
//   user_nrow  : 0 = user_rc selects a row, 1 = a column
//   user_error : player switch-error flag, blocks the player move
//   win        : board-solved flag, honoured only while playing
//   row_en     : one-hot row enable, valid with fire
//   col_en     : one-hot column enable, valid with fire
//   fire       : single-cycle move strobe
//   busy       : high while scrambling
//   user_mode  : high while player moves are accepted
//   move_count : moves issued in the current scramble or play phase (saturating)
//   solved     : high while in SOLVED
module scramble_sequencer #(
   parameter int unsigned NUM_MOVES  = 16,
   parameter int unsigned GAP_CYCLES = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] rand_in,
   input  logic       user_fire,
   input  logic [3:0] user_rc,
   input  logic       user_nrow,
   input  logic       user_error,
   input  logic       win,
   output logic [3:0] row_en,
   output logic [3:0] col_en,
   output logic       fire,
   output logic       busy,
   output logic       user_mode,
   output logic [7:0] move_count,
   output logic       solved
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_GAP    = 3'd2,
      S_PLAY   = 3'd3,
      S_SOLVED = 3'd4
   } state_t;

   localparam logic [7:0] NUM_MOVES_C = 8'(NUM_MOVES);
   localparam logic [7:0] GAP_LAST_C  = 8'(GAP_CYCLES - 1);

   state_t     state_r, state_s;
   logic [7:0] gap_cnt_r, gap_cnt_s;
   logic       prev_valid_r, prev_valid_s;
   logic [2:0] prev_move_r, prev_move_s;
   logic [2:0] scr_move_s;
   logic       user_ok_s;
   logic       fire_s;
   logic [3:0] row_s, col_s;
   logic [7:0] count_s;
   logic [7:0] count_inc_s;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [3:0] line_decode(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Next-state, move selection and next-output logic.
   always_comb begin
      state_s      = state_r;
      gap_cnt_s    = gap_cnt_r;
      prev_valid_s = prev_valid_r;
      prev_move_s  = prev_move_r;
      fire_s       = 1'b0;
      row_s        = 4'd0;
      col_s        = 4'd0;
      count_s      = move_count;
      count_inc_s  = (move_count == 8'hFF) ? move_count : move_count + 8'd1;
      user_ok_s    = user_fire && !user_error && is_one_hot(user_rc);

      // Repeating the previous scramble move would undo it, so bump the index.
      if (prev_valid_r && (rand_in == prev_move_r)) begin
         scr_move_s = {rand_in[2], rand_in[1:0] + 2'd1};
      end else begin
         scr_move_s = rand_in;
      end

      if (start) begin
         // A start pulse in any state begins a fresh scramble with no history.
         state_s      = S_ISSUE;
         gap_cnt_s    = 8'd0;
         count_s      = 8'd0;
         prev_valid_s = 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               state_s = S_IDLE;
            end
            S_ISSUE: begin
               state_s      = S_GAP;
               gap_cnt_s    = 8'd0;
               fire_s       = 1'b1;
               row_s        = scr_move_s[2] ? 4'd0 : line_decode(scr_move_s[1:0]);
               col_s        = scr_move_s[2] ? line_decode(scr_move_s[1:0]) : 4'd0;
               count_s      = count_inc_s;
               prev_valid_s = 1'b1;
               prev_move_s  = scr_move_s;
            end
            S_GAP: begin
               // move_count already includes the move fired on GAP entry.
               if (gap_cnt_r >= GAP_LAST_C) begin
                  gap_cnt_s = 8'd0;
                  if (move_count >= NUM_MOVES_C) begin
                     state_s = S_PLAY;
                     count_s = 8'd0;
                  end else begin
                     state_s = S_ISSUE;
                  end
               end else begin
                  gap_cnt_s = gap_cnt_r + 8'd1;
               end
            end
            S_PLAY: begin
               if (user_ok_s && !fire) begin
                  fire_s  = 1'b1;
                  row_s   = user_nrow ? 4'd0 : user_rc;
                  col_s   = user_nrow ? user_rc : 4'd0;
                  count_s = count_inc_s;
               end else begin
                  fire_s  = 1'b0;
               end
               if (win) begin
                  state_s = S_SOLVED;
               end else begin
                  state_s = S_PLAY;
               end
            end
            S_SOLVED: begin
               state_s = S_SOLVED;
            end
            default: begin
               state_s = S_IDLE;
            end
         endcase
      end
   end

   // State, history and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= S_IDLE;
         gap_cnt_r    <= 8'd0;
         prev_valid_r <= 1'b0;
         prev_move_r  <= 3'd0;
         fire         <= 1'b0;
         row_en       <= 4'd0;
         col_en       <= 4'd0;
         busy         <= 1'b0;
         user_mode    <= 1'b0;
         solved       <= 1'b0;
         move_count   <= 8'd0;
      end else begin
         state_r      <= state_s;
         gap_cnt_r    <= gap_cnt_s;
         prev_valid_r <= prev_valid_s;
         prev_move_r  <= prev_move_s;
         fire         <= fire_s;
         row_en       <= row_s;
         col_en       <= col_s;
         busy         <= (state_s == S_ISSUE) || (state_s == S_GAP);
         user_mode    <= (state_s == S_PLAY);
         solved       <= (state_s == S_SOLVED);
         move_count   <= count_s;
      end
   end

endmodule

// File: tb/tb_scramble_sequencer.sv
// tb_scramble_sequencer
//   Directed sequence with randomized move sources, checked against a
//   cycle-schedule reference model (scramble moves appear every
//   GAP+1 cycles, player moves one cycle after a legal pulse).
module tb_scramble_sequencer;

   localparam int NM = 4;
   localparam int GC = 2;
   localparam int PERIOD = GC + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] rand_in;
   logic       user_fire;
   logic [3:0] user_rc;
   logic       user_nrow;
   logic       user_error;
   logic       win;
   logic [3:0] row_en;
   logic [3:0] col_en;
   logic       fire;
   logic       busy;
   logic       user_mode;
   logic [7:0] move_count;
   logic       solved;

   int n_checks = 0;
   int n_errors = 0;
   int play_cnt = 0;
   logic [3:0] fixed_rows [NM];

   scramble_sequencer #(.NUM_MOVES(NM), .GAP_CYCLES(GC)) dut (
      .clk(clk), .reset(reset), .start(start), .rand_in(rand_in),
      .user_fire(user_fire), .user_rc(user_rc), .user_nrow(user_nrow),
      .user_error(user_error), .win(win), .row_en(row_en), .col_en(col_en),
      .fire(fire), .busy(busy), .user_mode(user_mode),
      .move_count(move_count), .solved(solved)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_fire"}, fire, 0);
      chk({tag, "_row"}, row_en, 0);
      chk({tag, "_col"}, col_en, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_umode"}, user_mode, 0);
      chk({tag, "_solved"}, solved, 0);
      chk({tag, "_mc"}, move_count, 0);
   endtask

   // Scramble from a start pulse; abort_at >= 0 stops after that loop step.
   task automatic run_scramble(input bit fixed, input logic [2:0] fixed_val, input int abort_at);
      bit         pv;
      int         ptype, pidx, mtype, midx, fires;
      logic [2:0] sampled;
      bit         done;
      pv = 0; ptype = 0; pidx = 0; fires = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_mc", move_count, 0);
      chk("start_fire", fire, 0);
      chk("start_umode", user_mode, 0);
      chk("start_solved", solved, 0);
      for (int c = 0; c < NM * PERIOD; c++) begin
         sampled    = fixed ? fixed_val : 3'($urandom_range(0, 7));
         rand_in    = sampled;
         // Legal-looking player moves and win must be ignored while scrambling.
         user_fire  = 1'($urandom_range(0, 1));
         user_rc    = 4'b0001 << $urandom_range(0, 3);
         user_nrow  = 1'($urandom_range(0, 1));
         user_error = 1'b0;
         win        = 1'($urandom_range(0, 1));
         tick();
         if (c % PERIOD == 0) begin
            mtype = int'(sampled[2]);
            midx  = int'(sampled[1:0]);
            if (pv && mtype == ptype && midx == pidx) midx = (midx + 1) % 4;
            pv = 1; ptype = mtype; pidx = midx;
            fires++;
            chk("scr_fire", fire, 1);
            chk("scr_row", row_en, (mtype == 0) ? (1 << midx) : 0);
            chk("scr_col", col_en, (mtype == 1) ? (1 << midx) : 0);
            if (fixed) fixed_rows[fires-1] = row_en;
         end else begin
            chk("gap_fire", fire, 0);
            chk("gap_row", row_en, 0);
            chk("gap_col", col_en, 0);
         end
         done = (c == NM * PERIOD - 1);
         chk("scr_busy", busy, !done);
         chk("scr_umode", user_mode, done);
         chk("scr_solved", solved, 0);
         chk("scr_mc", move_count, done ? 0 : fires);
         if (c == abort_at) break;
      end
      user_fire = 1'b0;
      win       = 1'b0;
      play_cnt  = 0;
   endtask

   task automatic user_move(input logic [3:0] rc, input logic nrow, input logic err, input bit in_play);
      bit ok;
      ok = in_play && !err && $onehot(rc);
      if (ok) play_cnt = (play_cnt < 255) ? play_cnt + 1 : 255;
      user_rc = rc; user_nrow = nrow; user_error = err; user_fire = 1'b1;
      tick();
      user_fire = 1'b0; user_error = 1'b0;
      chk("user_fire", fire, ok);
      chk("user_row", row_en, (ok && !nrow) ? rc : 4'd0);
      chk("user_col", col_en, (ok && nrow) ? rc : 4'd0);
      chk("user_mc", move_count, play_cnt);
      tick();
      chk("user_fire_after", fire, 0);
   endtask

   task automatic idle_check(input string tag);
      for (int i = 0; i < 6; i++) begin
         rand_in    = 3'($urandom_range(0, 7));
         user_fire  = 1'($urandom_range(0, 1));
         user_rc    = 4'b0001 << $urandom_range(0, 3);
         user_error = 1'b0;
         win        = 1'($urandom_range(0, 1));
         tick();
         chk_quiet(tag);
      end
      user_fire = 1'b0;
      win       = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; rand_in = 3'd0; user_fire = 1'b0;
      user_rc = 4'd0; user_nrow = 1'b0; user_error = 1'b0; win = 1'b0;
      repeat (3) tick();
      chk_quiet("reset");
      reset = 1'b0;
      idle_check("idle");

      // Constant rand_in: alternate index to avoid cancelling moves.
      run_scramble(1'b1, 3'b001, -1);
      chk("anticancel_0", fixed_rows[0], 4'b0010);
      chk("anticancel_1", fixed_rows[1], 4'b0100);
      chk("anticancel_2", fixed_rows[2], 4'b0010);
      chk("anticancel_3", fixed_rows[3], 4'b0100);

      user_move(4'b0100, 1'b1, 1'b0, 1'b1);
      user_move(4'b0100, 1'b1, 1'b1, 1'b1);
      user_move(4'b0110, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         user_move(($urandom_range(0, 1) != 0) ? (4'b0001 << $urandom_range(0, 3))
                                                : 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b1);
      end

      win = 1'b1;
      tick();
      win = 1'b0;
      chk("win_solved", solved, 1);
      chk("win_umode", user_mode, 0);
      chk("win_busy", busy, 0);
      user_move(4'b0010, 1'b0, 1'b0, 1'b0);
      chk("solved_hold", solved, 1);

      // Start from SOLVED, random moves with gating stimulus.
      run_scramble(1'b0, 3'd0, -1);
      // Win on the very first PLAY cycle.
      win = 1'b1;
      tick();
      win = 1'b0;
      chk("win_first_play", solved, 1);

      // Restarts landing in GAP and in ISSUE.
      run_scramble(1'b0, 3'd0, 4);
      run_scramble(1'b0, 3'd0, 5);
      run_scramble(1'b0, 3'd0, -1);

      for (int i = 0; i < 260; i++) begin
         user_move(4'b0001 << $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end
      chk("saturate", move_count, 255);

      // Restart from PLAY, then asynchronous reset while fire is high.
      run_scramble(1'b0, 3'd0, 6);
      chk("pre_reset_fire", fire, 1);
      #3;
      reset = 1'b1;
      #1;
      chk_quiet("async_reset");
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk_quiet("post_reset");
      idle_check("post_reset_idle");
      run_scramble(1'b0, 3'd0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
